// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: the redirect/stall inputs coming from the branch
// decision logic and the fetch address/flush outputs going to the pipeline.
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            branch;
  logic            is_jalr;
  logic [XLEN-1:0] target;
  logic            stall;
  logic            imem_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            imem_req;
  logic            flush;
  logic            misalign_exc;

  // Controller side: consumes redirects, produces the fetch PC and flush.
  modport master (
    input  branch, is_jalr, target, stall, imem_ready,
    output pc, pc_plus4, imem_req, flush, misalign_exc
  );

  // Environment side: branch logic / hazard unit / instruction memory.
  modport slave (
    output branch, is_jalr, target, stall, imem_ready,
    input  pc, pc_plus4, imem_req, flush, misalign_exc
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-redirect controller. Takes resolved branches,
// steers the fetch PC, raises a multi-cycle flush after every redirect and
// vectors misaligned control-transfer targets to a trap address.
module pc_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(32'h0000_0100),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter is loaded with one less than the pulse length because the
  // redirect edge itself already drives the first flush cycle.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [3:0]      fcnt_reg, fcnt_next;
  logic            flush_reg, flush_next;
  logic            misalign_reg, misalign_next;
  logic [XLEN-1:0] eff;
  logic [XLEN-1:0] pc_inc;
  logic            advance;
  logic            imem_req;

  // jalr targets have bit 0 cleared; only bit 1 can then make them misaligned.
  assign eff     = bus.is_jalr ? {bus.target[XLEN-1:1], 1'b0} : bus.target;
  assign pc_inc  = pc_reg + XLEN'(4);
  assign advance = bus.imem_ready && !bus.stall;

  // State register: FSM state plus all registered outputs, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      fcnt_reg     <= 4'd0;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      fcnt_reg     <= fcnt_next;
      flush_reg    <= flush_next;
      misalign_reg <= misalign_next;
    end
  end

  // Next-state logic: redirect beats stall/not-ready; FLUSH ignores branch.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fcnt_next     = fcnt_reg;
    flush_next    = flush_reg;
    misalign_next = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (bus.branch) begin
          if (eff[1]) begin
            pc_next       = TRAP_VEC;
            misalign_next = 1'b1;
          end else begin
            pc_next = eff;
          end
          flush_next = 1'b1;
          fcnt_next  = FLUSH_INIT;
          state_next = FLUSH;
        end else if (advance) begin
          pc_next = pc_inc;
        end
      end
      FLUSH: begin
        if (advance) begin
          pc_next = pc_inc;
        end
        if (fcnt_reg != 4'd0) begin
          fcnt_next = fcnt_reg - 4'd1;
        end else begin
          flush_next = 1'b0;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
        flush_next = 1'b0;
        fcnt_next  = 4'd0;
      end
    endcase
  end

  // Output decode: fetch is requested in every state except the boot cycle.
  always_comb begin
    imem_req = (state_reg != BOOT);
  end

  assign bus.imem_req     = imem_req;
  assign bus.pc           = pc_reg;
  assign bus.pc_plus4     = pc_inc;
  assign bus.flush        = flush_reg;
  assign bus.misalign_exc = misalign_reg;

endmodule
